// File: rtl/wb_master_cmd.sv
// Wishbone classic single-transaction master driven by a valid/ready command port.
// Optional bus timeout enabled by defining WB_MASTER_CMD_TIMEOUT_EN.
module wb_master_cmd #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SELECT_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic                    cmd_we,
  input  logic [SELECT_WIDTH-1:0] cmd_sel,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_err,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   dat_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  output logic                    cyc_o,
  input  logic                    ack_i,
  input  logic                    err_i
);

  // Handshakes: a command transfers when cmd_valid && cmd_ready at a rising
  // edge; a response transfers when rsp_valid && rsp_ready at a rising edge.
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  state_t state;

  logic to_hit;

  assign cmd_ready = (state == IDLE);

`ifdef WB_MASTER_CMD_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Counter sits at zero outside BUS, so it is already cleared on BUS entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == BUS) begin
      to_cnt <= to_cnt + 16'd1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign to_hit = (to_cnt == 16'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      adr_o     <= '0;
      dat_o     <= '0;
      we_o      <= 1'b0;
      sel_o     <= '0;
      cyc_o     <= 1'b0;
      stb_o     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            adr_o <= cmd_addr;
            dat_o <= cmd_data;
            we_o  <= cmd_we;
            sel_o <= cmd_sel;
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            state <= BUS;
          end
        end
        BUS: begin
          // ack_i wins over a timeout in the final cycle; err_i wins over ack_i.
          if (ack_i || err_i || to_hit) begin
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= err_i || !ack_i;
            rsp_data  <= (ack_i && !err_i && !we_o) ? dat_i : '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_cmd.sv
// Randomized scoreboard bench for wb_master_cmd with a behavioural Wishbone slave.
module tb_wb_master_cmd;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 8;
`ifdef WB_MASTER_CMD_TIMEOUT_EN
  localparam bit TE = 1'b1;
`else
  localparam bit TE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic          cmd_we = 1'b0;
  logic [SW-1:0] cmd_sel = '0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_err;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [AW-1:0] adr_o;
  logic [DW-1:0] dat_o;
  logic [DW-1:0] dat_i;
  logic          we_o;
  logic [SW-1:0] sel_o;
  logic          stb_o;
  logic          cyc_o;
  logic          ack_i;
  logic          err_i;

  always #5 clk = ~clk;

  wb_master_cmd #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SELECT_WIDTH(SW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_we(cmd_we), .cmd_sel(cmd_sel),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .adr_o(adr_o), .dat_o(dat_o), .dat_i(dat_i), .we_o(we_o), .sel_o(sel_o),
    .stb_o(stb_o), .cyc_o(cyc_o), .ack_i(ack_i), .err_i(err_i)
  );

  // kind: 0 = ack, 1 = err, 2 = ack+err; wait_n = stb cycles before the reply
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          we;
    logic [SW-1:0] sel;
    int            wait_n;
    int            kind;
    int            n_stb;
  } plan_t;

  plan_t         plan_q[$];
  logic [DW:0]   exp_q[$];
  logic [DW-1:0] model_mem[int];
  logic [DW-1:0] slave_mem[int];

  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;
  int last_hs = -10;
  int rdy_mode = 1;
  int hold = 0;
  bit abandoned = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < SW; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] mrd(input int a);
    return model_mem.exists(a) ? model_mem[a] : '0;
  endfunction

  function automatic logic [DW-1:0] srd(input int a);
    return slave_mem.exists(a) ? slave_mem[a] : '0;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  // Driver: compute the expected response from the slave plan, then present the command.
  task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic we,
                       input logic [SW-1:0] s, input int wn, input int kind);
    plan_t p;
    int n;
    bit to;
    p.addr = a; p.data = d; p.we = we; p.sel = s; p.wait_n = wn; p.kind = kind;
    to = TE && (wn + 1 > TO);
    p.n_stb = to ? TO : wn + 1;
    if (to || kind != 0) exp_q.push_back({1'b1, {DW{1'b0}}});
    else if (we) begin
      exp_q.push_back({1'b0, {DW{1'b0}}});
      model_mem[int'(a)] = merge(mrd(int'(a)), d, s);
    end else exp_q.push_back({1'b0, mrd(int'(a))});
    plan_q.push_back(p);
    @(negedge clk);
    cmd_addr = a; cmd_data = d; cmd_we = we; cmd_sel = s; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      chk("cmd_accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    chk("accept_after_rsp_hs", 64'(cyc_cnt + 1 > last_hs), 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_addr = $urandom; cmd_data = $urandom; cmd_we = 1'($urandom_range(0, 1));
    cmd_sel = 4'($urandom_range(0, 15));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || cmd_valid) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", 0, 1);
  endtask

  // Behavioural slave: follows the plan while strobed, random noise otherwise.
  initial begin
    bit    active;
    int    scnt;
    plan_t cur;
    active = 1'b0; scnt = 0;
    cur.addr = '0; cur.data = '0; cur.we = 1'b0; cur.sel = '0;
    cur.wait_n = 0; cur.kind = 0; cur.n_stb = 0;
    ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    forever begin
      @(negedge clk);
      if (cyc_o && stb_o) begin
        if (!active) begin
          active = 1'b1;
          scnt = 0;
          if (plan_q.size() == 0) chk("strobe_without_command", 0, 1);
          else cur = plan_q.pop_front();
        end else scnt++;
        chk("adr_o", adr_o, cur.addr);
        chk("dat_o", dat_o, cur.data);
        chk("we_o", we_o, cur.we);
        chk("sel_o", sel_o, cur.sel);
        if (scnt == cur.wait_n) begin
          ack_i = (cur.kind != 1);
          err_i = (cur.kind != 0);
          if (cur.kind == 0 && cur.we)
            slave_mem[int'(cur.addr)] = merge(srd(int'(cur.addr)), cur.data, cur.sel);
          dat_i = (cur.kind == 0 && !cur.we) ? srd(int'(cur.addr)) : $urandom;
        end else begin
          ack_i = 1'b0; err_i = 1'b0; dat_i = $urandom;
        end
      end else begin
        if (active) begin
          if (!abandoned) chk("stb_cycles", 64'(scnt + 1), 64'(cur.n_stb));
          active = 1'b0;
          abandoned = 1'b0;
        end
        ack_i = 1'($urandom_range(0, 1));
        err_i = ($urandom_range(0, 3) == 0);
        dat_i = $urandom;
      end
    end
  end

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rsp_valid) hold++;
      else hold = 0;
      case (rdy_mode)
        0:       rsp_ready = 1'($urandom_range(0, 1));
        1:       rsp_ready = 1'b1;
        default: rsp_ready = (hold > 5);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each response handshake, checks holding.
  initial begin
    logic [DW:0] held;
    logic [DW:0] e;
    bit          pend;
    pend = 1'b0; held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 1'b0;
      else if (rsp_valid) begin
        chk("cmd_ready_in_resp", cmd_ready, 0);
        if (pend) chk("rsp_hold", {rsp_err, rsp_data}, held);
        if (rsp_ready) begin
          if (exp_q.size() == 0) chk("unexpected_rsp", 0, 1);
          else begin
            e = exp_q.pop_front();
            chk("rsp_err", rsp_err, e[DW]);
            chk("rsp_data", rsp_data, e[DW-1:0]);
          end
          last_hs = cyc_cnt + 1;
          pend = 1'b0;
        end else begin
          pend = 1'b1;
          held = {rsp_err, rsp_data};
        end
      end else pend = 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cyc_o", cyc_o, 0);
    chk("rst_stb_o", stb_o, 0);
    chk("rst_we_o", we_o, 0);
    chk("rst_adr_o", adr_o, 0);
    chk("rst_dat_o", dat_o, 0);
    chk("rst_sel_o", sel_o, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    // preloaded read with response held off for 5 cycles
    model_mem[16] = 32'hCAFEF00D;
    slave_mem[16] = 32'hCAFEF00D;
    rdy_mode = 2;
    issue(32'h10, 32'h1234_5678, 1'b0, 4'hF, 2, 0);
    drain();

    rdy_mode = 1;
    issue(32'h10, 32'hDEADBEEF, 1'b1, 4'hF, 1, 0);
    issue(32'h10, 32'h0, 1'b0, 4'hF, 0, 0);
    issue(32'h20, 32'h0, 1'b0, 4'hF, 0, 2);
    issue(32'h24, 32'h5555_AAAA, 1'b1, 4'h3, 3, 1);
    issue(32'h10, 32'hFFFF_0000, 1'b1, 4'h6, 0, 0);
    issue(32'h10, 32'h0, 1'b0, 4'hF, 1, 0);
    drain();

`ifdef WB_MASTER_CMD_TIMEOUT_EN
    issue(32'h30, 32'h0, 1'b0, 4'hF, 20, 0);
    issue(32'h10, 32'h0, 1'b0, 4'hF, TO - 1, 0);
    issue(32'h34, 32'h0, 1'b0, 4'hF, TO - 2, 1);
    drain();
`endif

    // reset pulsed during the third BUS cycle of a read
    issue(32'h14, 32'h0, 1'b0, 4'hF, 30, 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    abandoned = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_cyc_o", cyc_o, 0);
    chk("rstmid_stb_o", stb_o, 0);
    chk("rstmid_cmd_ready", cmd_ready, 1);
    chk("rstmid_rsp_valid", rsp_valid, 0);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    repeat (4) begin
      @(negedge clk);
      chk("rstmid_no_rsp", rsp_valid, 0);
    end
    issue(32'h18, 32'hA5A5_5A5A, 1'b1, 4'hF, 1, 0);
    issue(32'h18, 32'h0, 1'b0, 4'hF, 0, 0);
    drain();

    // back-to-back with rsp_ready high
    issue(32'h1C, 32'h0102_0304, 1'b1, 4'hF, 0, 0);
    issue(32'h1C, 32'h0, 1'b0, 4'hF, 0, 0);
    issue(32'h10, 32'h0, 1'b0, 4'hF, 0, 0);
    drain();

    rdy_mode = 0;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      issue(32'($urandom_range(0, 15) * 4), $urandom, 1'($urandom_range(0, 1)),
            4'($urandom_range(1, 15)), $urandom_range(0, TE ? 11 : 5),
            (k < 7) ? 0 : ((k < 9) ? 1 : 2));
    end
    drain();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
